grf_wb_loader: RTL and testbench
================================

Name: grf_wb_loader

Overview:
- Writeback-side producer for the byte-enabled general register file.
- Accepts one retiring instruction per handshake from the MEM stage: either an ALU result or a load.
- For loads, waits for the data-memory response, then aligns and extends the data.
- Emits a single-cycle register-file write (WriteAddr/WriteEnable/WriteData).
- LWL/LWR are realised purely through partial byte enables, so no old-rt merge is needed.

Parameters:
- PC_W, 32, width of the PC carried with each write for trace/debug.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Clr  in  1  reset, synchronous, active-high.
- req_valid  in  1  MEM stage offers an instruction.
- req_ready  out  1  block accepts the offer this cycle.
- req_op  in  3  0=ALU, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=LWL, 7=LWR.
- req_addr_lo  in  2  effective address bits [1:0].
- req_dest  in  5  destination register number.
- req_data  in  32  ALU result (ignored for loads).
- req_pc  in  PC_W  instruction PC.
- flush  in  1  cancel the in-flight load (exception/eret).
- mem_rvalid  in  1  data-memory read data valid, one-cycle pulse.
- mem_rdata  in  32  data-memory read word, little-endian.
- dm_stall  out  1  pipeline must hold; a load is awaiting data.
- WriteAddr  out  5  register-file write address.
- WriteEnable  out  4  per-byte write enable; nonzero for exactly one cycle per retired write.
- WriteData  out  32  byte-lane-aligned write data.
- WritePC  out  PC_W  PC of the instruction being written.

Behaviour:
- States:
  - IDLE
  - WAIT: load issued, data pending.
  - DRAIN: flushed load, response still owed.
- All outputs are registered.
- Reset (Clr=1, at any state including WAIT/DRAIN):
  - Next state IDLE.
  - WriteEnable=0, WriteAddr=0, WriteData=0, WritePC=0, dm_stall=0.
  - Any later mem_rvalid is ignored as spurious.
- req_ready=1 only in IDLE; 0 in WAIT and DRAIN. Handshake fires when req_valid && req_ready.
- Handshake with op=ALU:
  - Next cycle WriteAddr=req_dest, WriteData=req_data, WriteEnable=4'b1111, WritePC=req_pc.
  - State stays IDLE.
  - Back-to-back ALU ops give one write per cycle.
- Handshake with a load op:
  - Latch op, addr_lo, dest and pc; go to WAIT.
  - dm_stall=1 from the next cycle for as long as state is WAIT.
- WAIT:
  - On mem_rvalid, the write appears on the next cycle and state returns to IDLE. dm_stall drops in that same cycle.
  - Response the same cycle as entry into WAIT is legal, giving 2-cycle load-to-write latency minimum.
- Load alignment, with b = mem byte at addr_lo:
  - LB: sign-extend b. LBU: zero-extend b. Both WE=1111.
  - LH/LHU: halfword at addr_lo[1] (addr_lo[0] ignored; misalignment is trapped upstream), sign/zero-extended, WE=1111.
  - LW: mem_rdata, WE=1111.
  - LWL by addr_lo:
    - 0: WE=1000, data[31:24]=mem[7:0].
    - 1: WE=1100, data[31:16]=mem[15:0].
    - 2: WE=1110, data[31:8]=mem[23:0].
    - 3: WE=1111, data=mem.
  - LWR by addr_lo:
    - 0: WE=1111, data=mem.
    - 1: WE=0111, data[23:0]=mem[31:8].
    - 2: WE=0011, data[15:0]=mem[31:16].
    - 3: WE=0001, data[7:0]=mem[31:24].
  - Disabled lanes of WriteData are 0.
- req_dest=0: the write cycle still occurs (WritePC valid), but WriteEnable is forced to 0000.
- flush:
  - In IDLE: no effect; an ALU write issued the previous cycle still completes.
  - In WAIT without mem_rvalid: go to DRAIN; dm_stall=0, no write.
  - In WAIT with mem_rvalid the same cycle: discard the data, go to IDLE, no write.
- DRAIN: on mem_rvalid, discard the data and go to IDLE. req_ready stays 0 until then.
- mem_rvalid in IDLE: ignored.
- Outside the write cycle, WriteEnable=0. WriteAddr/WriteData/WritePC hold their last values.

Test Plan:
- Reset, then ALU op dest=5, data=32'hDEADBEEF -> next cycle WriteEnable=1111, WriteAddr=5, WriteData=DEADBEEF; following cycle WriteEnable=0000.
- LB addr_lo=2, mem_rdata=32'h1280_3456 returned 3 cycles after accept -> dm_stall=1 for 3 cycles, then WriteData=FFFF_FF80, WE=1111. The same with LBU -> 0000_0080.
- LWL addr_lo=1, mem_rdata=32'hAABB_CCDD -> WE=1100, WriteData[31:16]=CCDD. LWR addr_lo=3 -> WE=0001, WriteData[7:0]=AA.
- Load dest=0 -> the write cycle occurs with WriteEnable=0000; ALU op dest=0 likewise.
- Load accepted, flush 1 cycle later, mem_rvalid 2 cycles later -> no write; req_ready=0 until the mem_rvalid cycle, then 1; dm_stall=0 after flush.
- Clr asserted in WAIT, mem_rvalid arrives the next cycle -> no write, state IDLE, all outputs 0, req_ready=1.

Source files
------------

// File: rtl/grf_wb_loader.sv
// Writeback producer for the byte-enabled register file: retires ALU results
// directly and turns load responses into aligned, byte-enabled writes.
//
// state | meaning
// IDLE  | ready for the next retiring instruction
// WAIT  | load accepted, data-memory response pending
// DRAIN | load flushed, response still owed and will be discarded
module grf_wb_loader #(
    parameter int PC_W = 32
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [1:0]      req_addr_lo,
    input  logic [4:0]      req_dest,
    input  logic [31:0]     req_data,
    input  logic [PC_W-1:0] req_pc,
    input  logic            flush,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    output logic            dm_stall,
    output logic [4:0]      WriteAddr,
    output logic [3:0]      WriteEnable,
    output logic [31:0]     WriteData,
    output logic [PC_W-1:0] WritePC
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [2:0] OP_ALU = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd6;
    localparam logic [2:0] OP_LWR = 3'd7;

    logic [1:0]      state, state_nxt;
    logic [2:0]      op_q;
    logic [1:0]      addr_q;
    logic [4:0]      dest_q;
    logic [PC_W-1:0] pc_q;

    logic [31:0] shr, shl, ld_data;
    logic [15:0] half;
    logic [3:0]  ld_we;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid && req_op != OP_ALU) state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid)  state_nxt = S_IDLE;
                else if (flush)  state_nxt = S_DRAIN;
            end
            S_DRAIN: if (mem_rvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // LWL/LWR merge with the old register value through partial byte enables.
    always_comb begin
        shr     = mem_rdata >> {addr_q, 3'b000};
        shl     = mem_rdata << {~addr_q, 3'b000};
        half    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        ld_we   = 4'b1111;
        case (op_q)
            OP_LB:   ld_data = {{24{shr[7]}}, shr[7:0]};
            OP_LBU:  ld_data = {24'd0, shr[7:0]};
            OP_LH:   ld_data = {{16{half[15]}}, half};
            OP_LHU:  ld_data = {16'd0, half};
            OP_LWL: begin
                ld_data = shl;
                ld_we   = 4'b1111 << ~addr_q;
            end
            OP_LWR: begin
                ld_data = shr;
                ld_we   = 4'b1111 >> addr_q;
            end
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            dm_stall    <= 1'b0;
            op_q        <= OP_ALU;
            addr_q      <= 2'd0;
            dest_q      <= 5'd0;
            pc_q        <= '0;
            WriteAddr   <= 5'd0;
            WriteEnable <= 4'd0;
            WriteData   <= 32'd0;
            WritePC     <= '0;
        end else begin
            state       <= state_nxt;
            req_ready   <= (state_nxt == S_IDLE);
            dm_stall    <= (state_nxt == S_WAIT);
            WriteEnable <= 4'd0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_op == OP_ALU) begin
                            WriteAddr   <= req_dest;
                            WriteData   <= req_data;
                            WritePC     <= req_pc;
                            WriteEnable <= (req_dest != 5'd0) ? 4'b1111 : 4'b0000;
                        end else begin
                            op_q   <= req_op;
                            addr_q <= req_addr_lo;
                            dest_q <= req_dest;
                            pc_q   <= req_pc;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid && !flush) begin
                        WriteAddr   <= dest_q;
                        WriteData   <= ld_data;
                        WritePC     <= pc_q;
                        WriteEnable <= (dest_q != 5'd0) ? ld_we : 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grf_wb_loader.sv
// Bench for grf_wb_loader: directed vector table, randomized loads/ALU ops
// against a byte-level reference model, and hand-written flush/reset sequences.
module tb_grf_wb_loader;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [1:0]  req_addr_lo;
    logic [4:0]  req_dest;
    logic [31:0] req_data;
    logic [31:0] req_pc;
    logic        flush;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        dm_stall;
    logic [4:0]  WriteAddr;
    logic [3:0]  WriteEnable;
    logic [31:0] WriteData;
    logic [31:0] WritePC;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    grf_wb_loader #(.PC_W(32)) dut (
        .Clk(Clk), .Clr(Clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr_lo(req_addr_lo), .req_dest(req_dest), .req_data(req_data),
        .req_pc(req_pc), .flush(flush), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .dm_stall(dm_stall), .WriteAddr(WriteAddr),
        .WriteEnable(WriteEnable), .WriteData(WriteData), .WritePC(WritePC)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: assemble the register write byte by byte from memory bytes.
    task automatic model(input logic [2:0] op, input logic [1:0] a, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] mem,
                         output logic [3:0] we, output logic [31:0] d);
        logic [7:0]  mb [4];
        logic [15:0] h;
        int          v;
        int          ai;
        ai = int'(a);
        for (int i = 0; i < 4; i++) mb[i] = mem[8*i +: 8];
        h  = a[1] ? {mb[3], mb[2]} : {mb[1], mb[0]};
        we = 4'b1111;
        d  = 32'd0;
        case (op)
            3'd0: d = alu;
            3'd1: begin v = int'($signed(mb[ai])); d = v; end
            3'd2: d = {24'd0, mb[ai]};
            3'd3: begin v = int'($signed(h)); d = v; end
            3'd4: d = {16'd0, h};
            3'd5: d = mem;
            3'd6: begin
                we = 4'b0000;
                for (int j = 0; j < 4; j++)
                    if (j >= 3 - ai) begin we[j] = 1'b1; d[8*j +: 8] = mb[j - (3 - ai)]; end
            end
            default: begin
                we = 4'b0000;
                for (int j = 0; j < 4; j++)
                    if (j <= 3 - ai) begin we[j] = 1'b1; d[8*j +: 8] = mb[j + ai]; end
            end
        endcase
        if (dest == 5'd0) we = 4'b0000;
    endtask

    // Issue one instruction; for loads return data lat cycles after acceptance.
    task automatic run_op(input logic [2:0] op, input logic [1:0] a, input logic [4:0] dest,
                          input logic [31:0] data, input logic [31:0] pc, input logic [31:0] mem,
                          input int lat, input logic [3:0] exp_we, input logic [31:0] exp_d);
        @(negedge Clk);
        chk("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr_lo = a; req_dest = dest;
        req_data = data; req_pc = pc;
        @(negedge Clk);
        req_valid = 1'b0; req_data = $urandom;
        if (op != 3'd0) begin
            for (int i = 1; i < lat; i++) begin
                chk("stall_wait", {31'd0, dm_stall}, 32'd1);
                chk("we_wait", {28'd0, WriteEnable}, 32'd0);
                mem_rdata = $urandom;
                @(negedge Clk);
            end
            chk("stall_wait", {31'd0, dm_stall}, 32'd1);
            chk("ready_wait", {31'd0, req_ready}, 32'd0);
            mem_rvalid = 1'b1; mem_rdata = mem;
            @(negedge Clk);
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            chk("stall_done", {31'd0, dm_stall}, 32'd0);
        end
        chk("we", {28'd0, WriteEnable}, {28'd0, exp_we});
        chk("waddr", {27'd0, WriteAddr}, {27'd0, dest});
        chk("wpc", WritePC, pc);
        if (exp_we != 4'd0) chk("wdata", WriteData, exp_d);
        @(negedge Clk);
        chk("we_after", {28'd0, WriteEnable}, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  a;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] mem;
        int          lat;
        logic [3:0]  we;
        logic [31:0] d;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [3:0]  mwe;
        logic [31:0] md;
        logic [2:0]  rop;
        logic [1:0]  ra;
        logic [4:0]  rd;
        logic [31:0] rdat, rmem;

        vecs[0]  = '{3'd0, 2'd0, 5'd5,  32'hDEADBEEF, 32'h0,         1, 4'b1111, 32'hDEADBEEF};
        vecs[1]  = '{3'd1, 2'd2, 5'd7,  32'h0,        32'h1280_3456, 3, 4'b1111, 32'hFFFF_FF80};
        vecs[2]  = '{3'd2, 2'd2, 5'd7,  32'h0,        32'h1280_3456, 3, 4'b1111, 32'h0000_0080};
        vecs[3]  = '{3'd6, 2'd1, 5'd9,  32'h0,        32'hAABB_CCDD, 2, 4'b1100, 32'hCCDD_0000};
        vecs[4]  = '{3'd7, 2'd3, 5'd9,  32'h0,        32'hAABB_CCDD, 1, 4'b0001, 32'h0000_00AA};
        vecs[5]  = '{3'd3, 2'd2, 5'd3,  32'h0,        32'h8001_1234, 1, 4'b1111, 32'hFFFF_8001};
        vecs[6]  = '{3'd4, 2'd3, 5'd3,  32'h0,        32'h8001_1234, 2, 4'b1111, 32'h0000_8001};
        vecs[7]  = '{3'd3, 2'd1, 5'd4,  32'h0,        32'h8001_9234, 1, 4'b1111, 32'hFFFF_9234};
        vecs[8]  = '{3'd5, 2'd0, 5'd31, 32'h0,        32'h1234_5678, 4, 4'b1111, 32'h1234_5678};
        vecs[9]  = '{3'd6, 2'd0, 5'd2,  32'h0,        32'hAABB_CCDD, 1, 4'b1000, 32'hDD00_0000};
        vecs[10] = '{3'd7, 2'd0, 5'd2,  32'h0,        32'hAABB_CCDD, 1, 4'b1111, 32'hAABB_CCDD};
        vecs[11] = '{3'd7, 2'd1, 5'd2,  32'h0,        32'hAABB_CCDD, 1, 4'b0111, 32'h00AA_BBCC};
        vecs[12] = '{3'd5, 2'd0, 5'd0,  32'h0,        32'h1111_2222, 2, 4'b0000, 32'h0};
        vecs[13] = '{3'd0, 2'd0, 5'd0,  32'h5555_AAAA, 32'h0,        1, 4'b0000, 32'h0};

        Clr = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr_lo = 2'd0; req_dest = 5'd0;
        req_data = 32'd0; req_pc = 32'd0; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge Clk);
        Clr = 1'b0;
        chk("rst_we", {28'd0, WriteEnable}, 32'd0);
        chk("rst_waddr", {27'd0, WriteAddr}, 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_wpc", WritePC, 32'd0);
        chk("rst_stall", {31'd0, dm_stall}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].dest, vecs[i].data, 32'h1000 + 32'(4*i),
                   vecs[i].mem, vecs[i].lat, vecs[i].we, vecs[i].d);

        // Back-to-back ALU ops, with flush in IDLE having no effect.
        @(negedge Clk);
        req_valid = 1'b1; req_op = 3'd0; req_dest = 5'd10; req_data = 32'h0A0A_0A0A; req_pc = 32'h200;
        @(negedge Clk);
        chk("b2b_we0", {28'd0, WriteEnable}, 32'hF);
        chk("b2b_d0", WriteData, 32'h0A0A_0A0A);
        req_dest = 5'd11; req_data = 32'h0B0B_0B0B; req_pc = 32'h204; flush = 1'b1;
        @(negedge Clk);
        req_valid = 1'b0;
        chk("b2b_we1", {28'd0, WriteEnable}, 32'hF);
        chk("b2b_a1", {27'd0, WriteAddr}, 32'd11);
        chk("b2b_d1", WriteData, 32'h0B0B_0B0B);
        flush = 1'b0;
        @(negedge Clk);
        chk("b2b_hold_d", WriteData, 32'h0B0B_0B0B);
        chk("b2b_hold_we", {28'd0, WriteEnable}, 32'd0);

        // mem_rvalid while idle is ignored.
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge Clk);
        mem_rvalid = 1'b0;
        chk("idle_rv_we", {28'd0, WriteEnable}, 32'd0);
        chk("idle_rv_ready", {31'd0, req_ready}, 32'd1);

        // Flush one cycle after accept, response one cycle after that.
        req_valid = 1'b1; req_op = 3'd5; req_dest = 5'd12; req_pc = 32'h300;
        @(negedge Clk);
        req_valid = 1'b0;
        chk("fl_stall", {31'd0, dm_stall}, 32'd1);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        chk("fl_drain_stall", {31'd0, dm_stall}, 32'd0);
        chk("fl_drain_ready", {31'd0, req_ready}, 32'd0);
        chk("fl_drain_we", {28'd0, WriteEnable}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge Clk);
        mem_rvalid = 1'b0;
        chk("fl_done_ready", {31'd0, req_ready}, 32'd1);
        chk("fl_done_we", {28'd0, WriteEnable}, 32'd0);

        // Flush coinciding with the response in WAIT.
        req_valid = 1'b1; req_op = 3'd1; req_dest = 5'd13; req_pc = 32'h400;
        @(negedge Clk);
        req_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1;
        @(negedge Clk);
        flush = 1'b0; mem_rvalid = 1'b0;
        chk("flrv_we", {28'd0, WriteEnable}, 32'd0);
        chk("flrv_ready", {31'd0, req_ready}, 32'd1);
        chk("flrv_stall", {31'd0, dm_stall}, 32'd0);

        // Clr in WAIT, then a now-spurious response.
        req_valid = 1'b1; req_op = 3'd5; req_dest = 5'd14; req_pc = 32'h500;
        @(negedge Clk);
        req_valid = 1'b0; Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge Clk);
        mem_rvalid = 1'b0;
        chk("clr_we", {28'd0, WriteEnable}, 32'd0);
        chk("clr_waddr", {27'd0, WriteAddr}, 32'd0);
        chk("clr_wdata", WriteData, 32'd0);
        chk("clr_wpc", WritePC, 32'd0);
        chk("clr_stall", {31'd0, dm_stall}, 32'd0);
        chk("clr_ready", {31'd0, req_ready}, 32'd1);

        for (int n = 0; n < 200; n++) begin
            rop  = 3'($urandom_range(0, 7));
            ra   = 2'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 31));
            rdat = $urandom;
            rmem = $urandom;
            model(rop, ra, rd, rdat, rmem, mwe, md);
            run_op(rop, ra, rd, rdat, $urandom, rmem, $urandom_range(1, 4), mwe, md);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
